// File: rtl/keypad_scanner.sv
// Column-scanning driver for a 5x4 active-low matrix keypad.
// Debounces press and release and emits one newkey pulse with a 5-bit keycode per keypress.
module keypad_scanner #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE_N = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [4:0] cols,
    output logic       newkey,
    output logic [4:0] keycode
);

    localparam int DW_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_N + 1);

    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(SCAN_DIV - 1);
    localparam logic [DW_W-1:0]  DWELL_ONE  = DW_W'(1);
    localparam logic [CNT_W-1:0] COUNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] COUNT_DONE = CNT_W'(DEBOUNCE_N);
    localparam logic [2:0]       COL_LAST   = 3'd4;
    localparam logic [4:0]       COLS_RESET = 5'b11110;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEB_PRESS,
        ST_EMIT,
        ST_HOLD
    } state_t;

    state_t           r_state;
    logic [3:0]       r_rows_meta;
    logic [3:0]       r_rows_s;
    logic [DW_W-1:0]  r_dwell;
    logic [2:0]       r_col;
    logic [4:0]       r_cols;
    logic             r_newkey;
    logic [4:0]       r_keycode;
    logic [4:0]       r_cand;
    logic [CNT_W-1:0] r_count;

    logic             w_sample;
    logic             w_single;
    logic [1:0]       w_row;
    logic [4:0]       w_key;
    logic [2:0]       w_next_col;
    logic [4:0]       w_next_cols;
    logic [CNT_W-1:0] w_count_inc;

    // NOTE: the synchroniser flops are reset to "no key" so a stale pre-reset
    // row value can never be sampled as a press right after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rows_meta <= 4'hF;
            r_rows_s    <= 4'hF;
        end else begin
            // NOTE: all sequential state uses non-blocking assignment so every
            // flop samples the pre-edge value of its inputs.
            r_rows_meta <= rows;
            r_rows_s    <= r_rows_meta;
        end
    end

    // Free-running dwell counter; its last count is both the sample point and the column boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dwell <= '0;
        end else if (w_sample) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= r_dwell + DWELL_ONE;
        end
    end

    assign w_sample = (r_dwell == DWELL_LAST);

    // NOTE: both outputs get a default before the case so no latch is inferred.
    always_comb begin
        w_single = 1'b0;
        w_row    = 2'd0;
        case (r_rows_s)
            4'b1110: begin w_single = 1'b1; w_row = 2'd0; end
            4'b1101: begin w_single = 1'b1; w_row = 2'd1; end
            4'b1011: begin w_single = 1'b1; w_row = 2'd2; end
            4'b0111: begin w_single = 1'b1; w_row = 2'd3; end
            default: begin w_single = 1'b0; w_row = 2'd0; end
        endcase
    end

    assign w_key       = {r_col, w_row};
    assign w_next_col  = (r_col == COL_LAST) ? 3'd0 : r_col + 3'd1;
    assign w_next_cols = ~(5'b00001 << w_next_col);
    assign w_count_inc = r_count + COUNT_ONE;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_SCAN;
            r_col     <= 3'd0;
            r_cols    <= COLS_RESET;
            r_newkey  <= 1'b0;
            r_keycode <= 5'd0;
            r_cand    <= 5'd0;
            r_count   <= '0;
        end else begin
            r_newkey <= 1'b0;
            case (r_state)
                ST_SCAN: begin
                    if (w_sample) begin
                        if (w_single) begin
                            r_cand  <= w_key;
                            r_count <= COUNT_ONE;
                            r_state <= (COUNT_ONE == COUNT_DONE) ? ST_EMIT : ST_DEB_PRESS;
                        end else begin
                            r_col  <= w_next_col;
                            r_cols <= w_next_cols;
                        end
                    end
                end
                ST_DEB_PRESS: begin
                    if (w_sample) begin
                        if (w_single && (w_key == r_cand)) begin
                            r_count <= w_count_inc;
                            if (w_count_inc == COUNT_DONE) begin
                                r_state <= ST_EMIT;
                            end
                        end else begin
                            r_count <= '0;
                            r_state <= ST_SCAN;
                            r_col   <= w_next_col;
                            r_cols  <= w_next_cols;
                        end
                    end
                end
                ST_EMIT: begin
                    r_newkey  <= 1'b1;
                    r_keycode <= r_cand;
                    r_count   <= '0;
                    r_state   <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (w_sample) begin
                        if (r_rows_s == 4'hF) begin
                            if (w_count_inc == COUNT_DONE) begin
                                r_count <= '0;
                                r_state <= ST_SCAN;
                                r_col   <= w_next_col;
                                r_cols  <= w_next_cols;
                            end else begin
                                r_count <= w_count_inc;
                            end
                        end else begin
                            r_count <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_SCAN;
                end
            endcase
        end
    end

    assign cols    = r_cols;
    assign newkey  = r_newkey;
    assign keycode = r_keycode;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_N=3.
// A key-matrix model drives rows from cols; timing is counted in clock edges from each reset.
module tb_keypad_scanner;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rows;
    logic [4:0] cols;
    logic       newkey;
    logic [4:0] keycode;

    logic [19:0] keys = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int base   = 0;
    int pulses = 0;
    int p0     = 0;
    logic       prev_nk = 1'b0;
    logic       dbl     = 1'b0;

    keypad_scanner #(
        .SCAN_DIV   (4),
        .DEBOUNCE_N (3)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .rows    (rows),
        .cols    (cols),
        .newkey  (newkey),
        .keycode (keycode)
    );

    always #5 clock = ~clock;

    // Key at column c, row r pulls row r low while column c is driven low.
    always_comb begin
        rows = 4'hF;
        for (int c = 0; c < 5; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!cols[c] && keys[4*c+r]) rows[r] = 1'b0;
            end
        end
    end

    always @(posedge clock) begin
        cyc     <= cyc + 1;
        prev_nk <= newkey;
        if (newkey) pulses <= pulses + 1;
        if (newkey && prev_nk) dbl <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        base  = cyc;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        base  = cyc;
    endtask

    task automatic wait_n(input int k);
        while (cyc < base + k) @(negedge clock);
    endtask

    function automatic int key_idx(input int c, input int r);
        return 4 * c + r;
    endfunction

    function automatic logic [4:0] col_drive(input int c);
        logic [4:0] v;
        v = 5'b11111;
        v[c] = 1'b0;
        return v;
    endfunction

    initial begin
        // 1: reset values and idle column rotation
        do_reset();
        check("rst_cols", cols, 5'b11110);
        check("rst_newkey", newkey, 1'b0);
        check("rst_keycode", keycode, 5'd0);
        for (int k = 0; k < 24; k++) begin
            wait_n(k);
            check($sformatf("idle_cols_%0d", k), cols, col_drive((k / 4) % 5));
        end

        // 2: stable key col2,row1; detect at edge 12, pulse 9 edges later
        keys = '0;
        keys[key_idx(2, 1)] = 1'b1;
        do_reset();
        p0 = pulses;
        wait_n(20);
        check("k9_before", newkey, 1'b0);
        wait_n(21);
        check("k9_pulse", newkey, 1'b1);
        check("k9_code", keycode, 5'd9);
        wait_n(22);
        check("k9_after", newkey, 1'b0);
        wait_n(60);
        check("k9_hold_cols", cols, 5'b11011);
        check("k9_one_pulse", pulses - p0, 1);
        keys = '0;
        wait_n(71);
        check("k9_rel_cols_hold", cols, 5'b11011);
        wait_n(72);
        check("k9_rel_cols_next", cols, 5'b10111);

        // 3: col4,row3 low/high/low across first samples, then stable
        keys = '0;
        do_reset();
        p0 = pulses;
        keys[key_idx(4, 3)] = 1'b1;
        wait_n(21);
        keys = '0;
        wait_n(23);
        check("k19_deb_cols", cols, 5'b01111);
        wait_n(24);
        check("k19_bounce_restart", cols, 5'b11110);
        wait_n(25);
        keys[key_idx(4, 3)] = 1'b1;
        wait_n(52);
        check("k19_before", newkey, 1'b0);
        check("k19_no_early", pulses - p0, 0);
        wait_n(53);
        check("k19_pulse", newkey, 1'b1);
        check("k19_code", keycode, 5'd19);
        wait_n(60);
        keys = '0;
        wait_n(80);
        check("k19_one_pulse", pulses - p0, 1);

        // 4: key col0,row0 with a 2-sample release bounce, then a clean second press
        keys = '0;
        keys[key_idx(0, 0)] = 1'b1;
        do_reset();
        p0 = pulses;
        wait_n(13);
        check("k0_pulse", newkey, 1'b1);
        check("k0_code", keycode, 5'd0);
        wait_n(14);
        keys = '0;
        wait_n(25);
        keys[key_idx(0, 0)] = 1'b1;
        wait_n(40);
        keys = '0;
        wait_n(51);
        check("k0_rel_cols_hold", cols, 5'b11110);
        wait_n(52);
        check("k0_rel_cols_next", cols, 5'b11101);
        wait_n(60);
        check("k0_bounce_one_pulse", pulses - p0, 1);
        keys[key_idx(0, 0)] = 1'b1;
        wait_n(80);
        check("k0_second_before", newkey, 1'b0);
        wait_n(81);
        check("k0_second_pulse", newkey, 1'b1);
        wait_n(82);
        keys = '0;
        wait_n(85);
        check("k0_two_pulses", pulses - p0, 2);

        // 5: two keys in one column are ignored until one is released
        keys = '0;
        keys[key_idx(0, 0)] = 1'b1;
        keys[key_idx(0, 2)] = 1'b1;
        do_reset();
        p0 = pulses;
        wait_n(40);
        check("multi_no_pulse", pulses - p0, 0);
        keys[key_idx(0, 2)] = 1'b0;
        wait_n(52);
        check("multi_before", newkey, 1'b0);
        wait_n(53);
        check("multi_pulse", newkey, 1'b1);
        check("multi_code", keycode, 5'd0);
        wait_n(60);
        check("multi_one_pulse", pulses - p0, 1);
        keys = '0;

        // 6: reset in DEB_PRESS and in HOLD with key col1,row2 held
        keys[key_idx(1, 2)] = 1'b1;
        do_reset();
        p0 = pulses;
        wait_n(9);
        pulse_reset();
        check("rst_deb_cols", cols, 5'b11110);
        check("rst_deb_newkey", newkey, 1'b0);
        wait_n(16);
        check("rst_deb_before", newkey, 1'b0);
        wait_n(17);
        check("rst_deb_reemit", newkey, 1'b1);
        check("rst_deb_code", keycode, 5'd6);
        wait_n(20);
        pulse_reset();
        check("rst_hold_cols", cols, 5'b11110);
        check("rst_hold_newkey", newkey, 1'b0);
        check("rst_hold_keycode", keycode, 5'd0);
        wait_n(17);
        check("rst_hold_reemit", newkey, 1'b1);
        check("rst_hold_code", keycode, 5'd6);
        wait_n(20);
        check("rst_pulses", pulses - p0, 2);
        keys = '0;

        check("no_double_pulse", dbl, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
